// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and buffer occupancy encodings for fifo_drain
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  // Encodings equal the number of held entries, so the state doubles as the count.
  typedef enum logic [1:0] {
    BUF0 = 2'd0,
    BUF1 = 2'd1,
    BUF2 = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_drain_buf.sv
// rtl/fifo_drain_buf.sv - two-entry in-order output buffer with push, pop, head data and held count
module fifo_drain_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            held
);

  buf_state_e            state;
  logic [DATA_WIDTH-1:0] tail_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= BUF0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (state)
            BUF0: begin
              head_data <= push_data;
              state     <= BUF1;
            end
            BUF1: begin
              tail_data <= push_data;
              state     <= BUF2;
            end
            default: ;
          endcase
        end
        2'b01: begin
          case (state)
            BUF1: state <= BUF0;
            BUF2: begin
              head_data <= tail_data;
              state     <= BUF1;
            end
            default: ;
          endcase
        end
        2'b11: begin
          // Occupancy is unchanged; the new word always lands behind any survivor.
          case (state)
            BUF1: head_data <= push_data;
            BUF2: begin
              head_data <= tail_data;
              tail_data <= push_data;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign held = state;

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains a synchronous FIFO into a valid/ready stream; FIFO_DRAIN_CNT_EN adds Drain_count
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Fifo_rst,
  input  logic                  Empty,
  input  logic [DATA_WIDTH-1:0] Read_data,
  output logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] Out_data,
  output logic                  Out_valid,
  input  logic                  Out_ready
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  Drain_count
`endif
);

  logic [1:0] held;
  logic       rd_pend;
  logic       pop;
  logic [2:0] occupancy;

  assign Out_valid = Fifo_rst && (held != 2'd0);
  assign pop       = Out_valid && Out_ready;

  // Words held plus the one in flight, net of this cycle's pop, must leave room.
  assign occupancy   = {1'b0, held} + {2'b00, rd_pend} - {2'b00, pop};
  assign Read_enable = Fifo_rst && !Empty && (occupancy < 3'd2);

  always_ff @(posedge Clock) begin
    if (!Fifo_rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= Read_enable;
    end
  end

  fifo_drain_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (Clock),
    .resetn    (Fifo_rst),
    .push      (rd_pend),
    .pop       (pop),
    .push_data (Read_data),
    .head_data (Out_data),
    .held      (held)
  );

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge Clock) begin
    if (!Fifo_rst) begin
      Drain_count <= '0;
    end else if (pop) begin
      Drain_count <= Drain_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of popped words.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of Drain_count.
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port Fifo_rst, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port Empty, input, 1, empty flag from the upstream synchronous FIFO.
REQ-006 SHALL have port Read_data, input, DATA_WIDTH, FIFO read word, valid on the cycle after an accepted Read_enable.
REQ-007 SHALL have port Read_enable, output, 1, pop request to the FIFO.
REQ-008 SHALL have port Out_data, output, DATA_WIDTH, stream data.
REQ-009 SHALL have port Out_valid, output, 1, stream valid.
REQ-010 SHALL have port Out_ready, input, 1, stream ready from the consumer.
REQ-011 SHALL have port Drain_count, output, CNT_WIDTH, words delivered (present only with FIFO_DRAIN_CNT_EN).

Function
REQ-012 SHALL hold a 2-entry output buffer, state BUF0 / BUF1 / BUF2 (entries held), plus a 1-bit pending flag Rd_pend.
REQ-013 SHALL define pop = Out_valid && Out_ready; one word transfers per pop.
REQ-014 SHALL drive Read_enable = !Empty && (held + Rd_pend - pop) < 2, combinationally.
REQ-015 SHALL set Rd_pend on the cycle after Read_enable=1 and clear it otherwise.
REQ-016 SHALL, when Rd_pend=1, write Read_data into the buffer tail on that clock edge.
REQ-017 SHALL drive Out_valid=1 exactly when held >= 1; Out_data is the oldest entry.
REQ-018 SHALL keep Out_data and Out_valid stable while Out_valid=1 and Out_ready=0.
REQ-019 SHALL, on simultaneous capture and pop, keep held unchanged and preserve word order.
REQ-020 SHALL never overflow: capture into BUF2 without pop is impossible by REQ-014.
REQ-021 SHALL sustain one word per cycle when Empty=0 and Out_ready=1 continuously.
REQ-022 SHALL have latency of 2 cycles from Empty falling (with buffer empty) to Out_valid=1.
REQ-023 SHALL treat Empty rising while Rd_pend=1 as irrelevant; the in-flight word is still captured.

Reset
REQ-024 SHALL, while Fifo_rst=0 at a clock edge, set state BUF0, Rd_pend=0, Out_data=0, Drain_count=0.
REQ-025 SHALL force Read_enable=0 and Out_valid=0 while Fifo_rst=0.
REQ-026 SHALL discard a pending read and all buffered words on reset mid-operation.

Configuration
REQ-027 SHALL, with macro FIFO_DRAIN_CNT_EN defined, provide Drain_count, incremented by 1 per pop, wrapping 2^CNT_WIDTH-1 -> 0.
REQ-028 SHALL, without FIFO_DRAIN_CNT_EN, omit the Drain_count port and counter; all other behaviour identical.

Structure
REQ-029 SHALL place DATA_WIDTH/CNT_WIDTH defaults and the BUF0/BUF1/BUF2 state encodings in shared package fifo_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module fifo_drain_buf (push, pop, head data, held count).

Verification
REQ-031 Reset: Fifo_rst=0 for 3 cycles with Empty=0 -> Read_enable=0, Out_valid=0, Out_data=0, Drain_count=0.
REQ-032 Streaming: FIFO loaded 0x01..0x10, Out_ready=1 -> 16 words in order, one per cycle after 2-cycle startup, Drain_count=16.
REQ-033 Backpressure: Out_ready=0 with 5 words queued -> exactly 2 pops issued, Out_data=0x01 held stable; Out_ready=1 -> 0x01..0x05 in order, no loss/duplicate.
REQ-034 Last word: single word 0xA5, Empty rises the cycle after Read_enable -> 0xA5 delivered once, no further Read_enable.
REQ-035 Reset mid-stream: Fifo_rst=0 while Rd_pend=1 and held=1 -> Out_valid=0 next cycle, pending word not output after release.
REQ-036 Wrap (FIFO_DRAIN_CNT_EN, CNT_WIDTH=4): 17 pops -> Drain_count reads 1.
